// File: rtl/sd_image_loader.sv
// sd_image_loader: fetches a raw little-endian RGB565 image from the SPI SD
// sector reader, packs byte pairs into pixels and streams them into the
// framebuffer write port, reporting done or fail to the controller.
// Build option: define LOADER_CHECKSUM_EN to add the 16-bit byte checksum
// output (mod-2^16 sum of every byte written to the framebuffer).
module sd_image_loader #(
    parameter int PIXELS         = 76800,
    parameter int ADDR_W         = 17,
    parameter int CHUNK_BLOCKS   = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [31:0]       img_sector,
    output logic              rd_start,
    output logic [31:0]       rd_sector,
    output logic [7:0]        rd_count,
    input  logic [7:0]        rd_data,
    input  logic              rd_valid,
    input  logic              rd_busy,
    input  logic              rd_error,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_wdata,
    output logic              loading,
    output logic              done,
`ifdef LOADER_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              fail
);

    localparam logic [31:0] TOTAL_BYTES  = 32'(PIXELS * 2);
    localparam logic [31:0] TOTAL_BLOCKS = 32'((PIXELS * 2 + 511) / 512);
    localparam logic [31:0] CHUNK_MAX    = 32'(CHUNK_BLOCKS);
    localparam logic [31:0] TMO_LAST     = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_BUSY,
        S_STREAM,
        S_CHUNK_END,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state;
    logic [31:0]       cur_sector;
    logic [31:0]       blocks_left;
    logic [ADDR_W-1:0] pix_addr;
    logic [31:0]       byte_total;   // bytes received in this load, padding included
    logic [31:0]       chunk_bytes;  // bytes received in the current reader request
    logic [31:0]       tmo_cnt;
    logic [7:0]        low_byte;
    logic              byte_phase;

    logic [7:0]        chunk;
    logic              tmo_expired;
    logic [31:0]       chunk_len;
    logic [31:0]       chunk_blk;

    // The last request of an image may be shorter than CHUNK_BLOCKS.
    assign chunk       = (blocks_left < CHUNK_MAX) ? blocks_left[7:0] : CHUNK_MAX[7:0];
    assign tmo_expired = (tmo_cnt >= TMO_LAST);
    // rd_count holds the size of the request in flight until the next REQ.
    assign chunk_len   = {15'd0, rd_count, 9'd0};
    assign chunk_blk   = {24'd0, rd_count};

    // Loader FSM: reader handshake, byte packing and framebuffer writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur_sector  <= '0;
            blocks_left <= '0;
            pix_addr    <= '0;
            byte_total  <= '0;
            chunk_bytes <= '0;
            tmo_cnt     <= '0;
            low_byte    <= '0;
            byte_phase  <= 1'b0;
            rd_start    <= 1'b0;
            rd_sector   <= '0;
            rd_count    <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            loading     <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            rd_start <= 1'b0;
            fb_we    <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A reader still busy initialising cannot take a request.
                    if (load_req && !rd_busy) begin
                        cur_sector  <= img_sector;
                        blocks_left <= TOTAL_BLOCKS;
                        pix_addr    <= '0;
                        byte_total  <= '0;
                        byte_phase  <= 1'b0;
                        fail        <= 1'b0;
                        loading     <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        checksum    <= '0;
`endif
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    rd_start    <= 1'b1;
                    rd_sector   <= cur_sector;
                    rd_count    <= chunk;
                    chunk_bytes <= '0;
                    tmo_cnt     <= '0;
                    state       <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (rd_busy) begin
                        tmo_cnt <= '0;
                        state   <= S_STREAM;
                    end else if (rd_error || tmo_expired) begin
                        fail    <= 1'b1;
                        loading <= 1'b0;
                        state   <= S_FAIL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                S_STREAM: begin
                    // A byte arriving with the busy fall is consumed first.
                    if (rd_valid) begin
                        chunk_bytes <= chunk_bytes + 32'd1;
                        byte_total  <= byte_total + 32'd1;
                        byte_phase  <= ~byte_phase;
                        tmo_cnt     <= '0;
                        if (!byte_phase) begin
                            low_byte <= rd_data;
                        end else if (byte_total < TOTAL_BYTES) begin
                            // Tail padding of the last sector fails this test.
                            fb_we    <= 1'b1;
                            fb_addr  <= pix_addr;
                            fb_wdata <= {rd_data, low_byte};
                            pix_addr <= pix_addr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            checksum <= checksum + {8'd0, rd_data} + {8'd0, low_byte};
`endif
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                    if (rd_error || (!rd_valid && tmo_expired)) begin
                        fail    <= 1'b1;
                        loading <= 1'b0;
                        state   <= S_FAIL;
                    end else if (!rd_busy) begin
                        state <= S_CHUNK_END;
                    end
                end
                S_CHUNK_END: begin
                    if (chunk_bytes != chunk_len) begin
                        fail    <= 1'b1;
                        loading <= 1'b0;
                        state   <= S_FAIL;
                    end else begin
                        cur_sector  <= cur_sector + chunk_blk;
                        blocks_left <= blocks_left - chunk_blk;
                        if (blocks_left == chunk_blk) begin
                            done    <= 1'b1;
                            loading <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_FAIL:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
